relu_ctrl: RTL and testbench
============================

// Module: relu_ctrl
// PURPOSE
//  Initiator/driver for the relu responder. Walks num_elem entries of the source
//  activation memory (1.7.24 fixed point) and issues one relu_en request per entry.
//  Holds data and address stable until the responder's output_valid arrives.
//  Captures each result into an internal DEPTH x DATA_W result buffer, exposed on a
//  registered read port for the next layer.
// PARAMETERS
//  DATA_W   32  datapath width (1.7.24)
//  ADDR_W   5   element address width
//  DEPTH    32  result buffer entries (= 2**ADDR_W)
//  TIMEOUT  15  max WAIT_RES cycles before abort
// PORTS
//  clk             in   1       clock
//  rst_n           in   1       synchronous active-low reset
//  start           in   1       run request, sampled only in IDLE
//  num_elem        in   ADDR_W+1  element count; 0 = empty run; >DEPTH clamps to DEPTH
//  busy            out  1       high in every state except IDLE
//  done            out  1       one-cycle pulse at end of run (normal or abort)
//  err             out  2       sticky until next accepted start; [0] timeout, [1] addr mismatch
//  src_rd_en       out  1       source memory read strobe
//  src_rd_addr     out  ADDR_W  source read address
//  src_rd_data     in   DATA_W  source data, valid 1 cycle after src_rd_en
//  relu_en         out  1       request to relu, one-cycle pulse
//  relu_in_data    out  DATA_W  operand, held from WAIT_RD capture until result
//  relu_in_addr    out  ADDR_W  element index, held with relu_in_data
//  relu_out_data   in   DATA_W  relu result
//  relu_out_addr   in   ADDR_W  relu result address
//  relu_out_valid  in   1       relu result strobe
//  res_rd_addr     in   ADDR_W  result buffer read address
//  res_rd_data     out  DATA_W  buffer[res_rd_addr], registered, 1-cycle latency
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//  - state=IDLE; idx=0; all outputs 0.
//  - Result buffer cleared to 0.
//  - Aborts any run in flight; no done pulse.
//  FSM: IDLE -> READ -> WAIT_RD -> ISSUE -> WAIT_RES -> (READ | DONE) -> IDLE
//  - IDLE: on start, latch n=min(num_elem,DEPTH), idx=0, clear err. Go READ, or DONE if n=0.
//  - READ: src_rd_en=1, src_rd_addr=idx.
//  - WAIT_RD: capture src_rd_data into relu_in_data; relu_in_addr=idx.
//  - ISSUE: relu_en=1 for exactly this cycle. Clear wait counter.
//  - WAIT_RES: relu_en=0, operands held.
//    - On relu_out_valid: write buf[relu_out_addr]=relu_out_data.
//    - If relu_out_addr!=relu_in_addr, set err[1] (write still performed).
//    - Then idx+1; go READ if idx+1<n, else DONE.
//    - If TIMEOUT cycles pass without valid: set err[0], no write, go DONE.
//  - DONE: done=1 for one cycle, go IDLE.
//  Timing: responder returns valid on the 3rd WAIT_RES cycle.
//  - Each element takes 6 cycles.
//  - done rises 6*n+1 cycles after the start-sampling edge (n=0: 1 cycle).
//  Boundaries:
//  - start while busy is ignored.
//  - relu_out_valid outside WAIT_RES is ignored: no write, no err.
//  - res_rd_addr equal to the address being written in the same cycle returns the old data.
//  - idx never wraps; the last element index is n-1 (max 31).
//  - No arithmetic is done on data; values pass through bit-exact.
// TESTING
//  1. Src=[+1.0(0x01000000), -0.5(0xFF800000), 0, 0x7FFFFFFF], num_elem=4
//     -> buf=[0x01000000, 0, 0, 0x7FFFFFFF]; done at cycle 25; err=0.
//  2. num_elem=0 -> done 1 cycle after start; no src_rd_en or relu_en; busy for 1 cycle.
//  3. num_elem=40 -> exactly 32 relu_en pulses (addr 0..31); done at cycle 193.
//  4. Responder stubbed to never assert valid, num_elem=3
//     -> err=01 after 15 WAIT_RES cycles; done pulses; buf[0] stays 0.
//  5. Stub returns relu_out_addr=idx^1 -> err[1]=1; data lands at the mismatched address.
//  6. rst_n=0 mid-WAIT_RES -> next cycle busy=0, relu_en=0, buf all 0; new start runs cleanly.

Source files
------------

// File: rtl/relu_ctrl.sv
// relu_ctrl: walks the source activation memory, issues one relu request
// per element and collects each result into a buffer for the next layer.
module relu_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_elem,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [DATA_W-1:0] src_rd_data,
  output logic              relu_en,
  output logic [DATA_W-1:0] relu_in_data,
  output logic [ADDR_W-1:0] relu_in_addr,
  input  logic [DATA_W-1:0] relu_out_data,
  input  logic [ADDR_W-1:0] relu_out_addr,
  input  logic              relu_out_valid,
  input  logic [ADDR_W-1:0] res_rd_addr,
  output logic [DATA_W-1:0] res_rd_data
);

  localparam int NW = ADDR_W + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_RD,
    S_ISSUE,
    S_WAIT_RES,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NW-1:0]     r_n;
  logic [NW-1:0]     w_n_clamp;
  logic [NW-1:0]     w_idx_inc;
  logic [ADDR_W-1:0] r_idx;
  logic [CW-1:0]     r_wcnt;
  logic              w_hit;
  logic              w_tmo;
  logic              w_last;
  logic              r_done;
  logic [1:0]        r_err;
  logic [DATA_W-1:0] r_in_data;
  logic [ADDR_W-1:0] r_in_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_buf [DEPTH];

  assign w_n_clamp = (num_elem > NW'(DEPTH)) ? NW'(DEPTH) : num_elem;
  assign w_idx_inc = NW'(r_idx) + NW'(1);
  assign w_last    = (w_idx_inc >= r_n);
  assign w_hit     = (r_state == S_WAIT_RES) && relu_out_valid;
  assign w_tmo     = (r_state == S_WAIT_RES) && !relu_out_valid &&
                     (r_wcnt == CW'(TIMEOUT - 1));

  // State register; reset aborts any run without a done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_state_nxt = (w_n_clamp == '0) ? S_DONE : S_READ;
      end
      S_READ:    w_state_nxt = S_WAIT_RD;
      S_WAIT_RD: w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_WAIT_RES;
      S_WAIT_RES: begin
        if (w_hit)
          w_state_nxt = w_last ? S_DONE : S_READ;
        else if (w_tmo)
          w_state_nxt = S_DONE;
      end
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Strobe outputs decoded from the current state
  always_comb begin
    busy        = (r_state != S_IDLE);
    src_rd_en   = (r_state == S_READ);
    src_rd_addr = (r_state == S_READ) ? r_idx : '0;
    relu_en     = (r_state == S_ISSUE);
  end

  // Datapath: run bookkeeping, operand hold, result capture, errors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n       <= '0;
      r_idx     <= '0;
      r_wcnt    <= '0;
      r_done    <= 1'b0;
      r_err     <= '0;
      r_in_data <= '0;
      r_in_addr <= '0;
      r_rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_done    <= (r_state == S_DONE);
      r_rd_data <= r_buf[res_rd_addr];
      if (r_state == S_IDLE && start) begin
        r_n   <= w_n_clamp;
        r_idx <= '0;
        r_err <= '0;
      end
      if (r_state == S_WAIT_RD) begin
        r_in_data <= src_rd_data;
        r_in_addr <= r_idx;
      end
      if (r_state == S_ISSUE) r_wcnt <= '0;
      if (r_state == S_WAIT_RES) r_wcnt <= r_wcnt + CW'(1);
      if (w_hit) begin
        r_buf[relu_out_addr] <= relu_out_data;
        if (relu_out_addr != r_in_addr) r_err[1] <= 1'b1;
        if (!w_last) r_idx <= w_idx_inc[ADDR_W-1:0];
      end
      if (w_tmo) r_err[0] <= 1'b1;
    end
  end

  assign done         = r_done;
  assign err          = r_err;
  assign relu_in_data = r_in_data;
  assign relu_in_addr = r_in_addr;
  assign res_rd_data  = r_rd_data;

endmodule

// File: tb/tb_relu_ctrl.sv
// tb_relu_ctrl: directed bench with a source memory model and a
// 3-cycle relu responder stub (normal / silent / address-flip modes).
module tb_relu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  num_elem = '0;
  logic        busy, done, src_rd_en, relu_en;
  logic [1:0]  err;
  logic [4:0]  src_rd_addr, relu_in_addr, relu_out_addr;
  logic [4:0]  res_rd_addr = '0;
  logic [31:0] src_rd_data = '0;
  logic [31:0] relu_in_data, relu_out_data, res_rd_data;
  logic        relu_out_valid;

  logic [31:0] src [32];
  logic        d1 = 0, d2 = 0, d3 = 0;
  logic [31:0] rsp_d = '0;
  logic [4:0]  rsp_a = '0;
  int          mode = 0;
  logic        fv = 0;
  logic        clr = 0;
  int          en_cnt = 0, rd_cnt = 0, busy_cnt = 0;
  logic [4:0]  last_a = '0;
  int          n_cmp = 0, n_bad = 0;
  int          dcyc;
  logic [31:0] v, rd6, rd7;

  always #5 clk = ~clk;

  relu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_elem(num_elem),
    .busy(busy), .done(done), .err(err),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr),
    .src_rd_data(src_rd_data),
    .relu_en(relu_en), .relu_in_data(relu_in_data),
    .relu_in_addr(relu_in_addr), .relu_out_data(relu_out_data),
    .relu_out_addr(relu_out_addr), .relu_out_valid(relu_out_valid),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data)
  );

  always @(posedge clk)
    if (src_rd_en) src_rd_data <= src[src_rd_addr];

  always @(posedge clk) begin
    d1 <= relu_en;
    d2 <= d1;
    d3 <= d2;
    if (relu_en) begin
      rsp_d <= relu_in_data;
      rsp_a <= relu_in_addr;
    end
  end

  assign relu_out_valid = fv | (d3 && mode != 1);
  assign relu_out_addr  = fv ? 5'd5 :
                          (mode == 2 ? rsp_a ^ 5'd1 : rsp_a);
  assign relu_out_data  = fv ? 32'h12345678 :
                          (rsp_d[31] ? 32'h0 : rsp_d);

  always @(posedge clk) begin
    if (clr) begin
      en_cnt   <= 0;
      rd_cnt   <= 0;
      busy_cnt <= 0;
    end else begin
      if (relu_en) begin
        en_cnt <= en_cnt + 1;
        last_a <= relu_in_addr;
      end
      if (src_rd_en) rd_cnt <= rd_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rdbuf(input int a, output logic [31:0] val);
    res_rd_addr = a[4:0];
    @(posedge clk);
    #1;
    val = res_rd_data;
  endtask

  task automatic run(input int n, input bit repoke, output int dc);
    num_elem = n[5:0];
    @(negedge clk);
    clr = 1;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    clr = 0;
    dc = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) rd6 = res_rd_data;
      if (k == 7) rd7 = res_rd_data;
      if (repoke && k == 10) start = 1;
      if (k == 11) start = 0;
      if (done) begin
        dc = k;
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) src[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_relu_en", relu_en, 0);
    chk("rst_src_rd_en", src_rd_en, 0);
    chk("rst_rd_data", res_rd_data, 0);
    rst_n = 1;

    src[0] = 32'h01000000;
    src[1] = 32'hFF800000;
    src[2] = 32'h00000000;
    src[3] = 32'h7FFFFFFF;
    run(4, 1, dcyc);
    chk("t1_done_cyc", dcyc, 25);
    chk("t1_err", err, 0);
    chk("t1_en_cnt", en_cnt, 4);
    chk("t1_rd_cnt", rd_cnt, 4);
    chk("t1_busy_cnt", busy_cnt, 25);
    rdbuf(0, v); chk("t1_buf0", v, 32'h01000000);
    rdbuf(1, v); chk("t1_buf1", v, 32'h0);
    rdbuf(2, v); chk("t1_buf2", v, 32'h0);
    rdbuf(3, v); chk("t1_buf3", v, 32'h7FFFFFFF);

    @(negedge clk);
    fv = 1;
    repeat (2) @(negedge clk);
    fv = 0;
    rdbuf(5, v); chk("stray_valid_buf5", v, 32'h0);
    chk("stray_valid_err", err, 0);

    run(0, 0, dcyc);
    chk("t2_done_cyc", dcyc, 1);
    chk("t2_en_cnt", en_cnt, 0);
    chk("t2_rd_cnt", rd_cnt, 0);
    chk("t2_busy_cnt", busy_cnt, 1);

    for (int i = 0; i < 32; i++) src[i] = 32'h00100000 * i;
    run(40, 0, dcyc);
    chk("t3_done_cyc", dcyc, 193);
    chk("t3_en_cnt", en_cnt, 32);
    chk("t3_last_addr", last_a, 31);
    chk("t3_err", err, 0);
    rdbuf(16, v); chk("t3_buf16", v, 32'h01000000);
    rdbuf(31, v); chk("t3_buf31", v, 32'h01F00000);

    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    mode = 1;
    run(3, 0, dcyc);
    chk("t4_done_cyc", dcyc, 19);
    chk("t4_err", err, 2'b01);
    chk("t4_en_cnt", en_cnt, 1);
    rdbuf(0, v); chk("t4_buf0", v, 32'h0);

    mode = 2;
    src[0] = 32'h00AA0000;
    src[1] = 32'h00550000;
    res_rd_addr = 5'd1;
    run(2, 0, dcyc);
    chk("t5_done_cyc", dcyc, 13);
    chk("t5_err", err, 2'b10);
    chk("t5_rdw_old", rd6, 32'h0);
    chk("t5_rdw_new", rd7, 32'h00AA0000);
    rdbuf(1, v); chk("t5_buf1", v, 32'h00AA0000);
    rdbuf(0, v); chk("t5_buf0", v, 32'h00550000);

    mode = 0;
    num_elem = 6'd4;
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_pre_busy", busy, 1);
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_relu_en", relu_en, 0);
    chk("t6_done", done, 0);
    chk("t6_err", err, 0);
    rst_n = 1;
    rdbuf(0, v); chk("t6_buf0", v, 32'h0);
    rdbuf(1, v); chk("t6_buf1", v, 32'h0);
    run(1, 0, dcyc);
    chk("t6_done_cyc", dcyc, 7);
    chk("t6_err_after", err, 0);
    rdbuf(0, v); chk("t6_buf0_after", v, 32'h00AA0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
